// File: rtl/jt12_regseq.sv
// Time-multiplexed register sequencer: operator and channel words live in
// circular shift registers and are updated by single masked write requests.
module jt12_regseq #(
  parameter int CH  = 6,
  parameter int OP  = 4,
  parameter int OPW = 44,
  parameter int CHW = 31,
  parameter int LAG = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_en,
  input  logic                                   wr_req,
  input  logic                                   wr_isop,
  input  logic [2:0]                             wr_ch,
  input  logic [1:0]                             wr_op,
  input  logic [((OPW > CHW) ? OPW : CHW)-1:0]   wr_data,
  input  logic [((OPW > CHW) ? OPW : CHW)-1:0]   wr_mask,
  output logic                                   busy,
  output logic                                   wr_err,
  output logic                                   overrun,
  output logic [2:0]                             cur_ch,
  output logic [1:0]                             cur_op,
  output logic                                   zero,
  output logic [OPW-1:0]                         op_q,
  output logic [CHW-1:0]                         ch_q
);

  localparam int DW = (OPW > CHW) ? OPW : CHW;
  localparam int N  = CH * OP;
  // Shift-register positions holding the word of the commit slot/channel,
  // i.e. the slot LAG steps behind the one presented on op_q/ch_q.
  localparam int OPOS = (N - LAG) % N;
  localparam int CPOS = (CH - (LAG % CH)) % CH;

  logic [2:0]     r_ch;
  logic [1:0]     r_op;
  logic           r_zero;
  logic [4:0]     r_cidx;
  logic [2:0]     r_cch;
  logic           r_busy;
  logic           r_err;
  logic           r_ovr;
  logic           r_isop;
  logic [4:0]     r_tidx;
  logic [2:0]     r_tch;
  logic [DW-1:0]  r_data;
  logic [DW-1:0]  r_mask;
  logic [OPW-1:0] r_op_sr [N];
  logic [CHW-1:0] r_ch_sr [CH];

  logic [2:0]     w_ch_nxt;
  logic [1:0]     w_op_nxt;
  logic           w_bad;
  logic [4:0]     w_tidx;
  logic           w_op_hit;
  logic           w_ch_hit;
  logic [OPW-1:0] w_op_merged;
  logic [CHW-1:0] w_ch_merged;
  logic           w_unused_bits;

  always_comb begin
    w_ch_nxt = r_ch + 3'd1;
    w_op_nxt = r_op;
    if (r_ch == 3'(CH - 1)) begin
      w_ch_nxt = 3'd0;
      w_op_nxt = (r_op == 2'(OP - 1)) ? 2'd0 : r_op + 2'd1;
    end
  end

  assign w_bad    = ({1'b0, wr_ch} >= 4'(CH)) || (wr_isop && ({1'b0, wr_op} >= 3'(OP)));
  assign w_tidx   = 5'(wr_op) * 5'(CH) + 5'(wr_ch);
  assign w_op_hit = r_busy && r_isop && (r_cidx == r_tidx);
  assign w_ch_hit = r_busy && !r_isop && (r_cch == r_tch);

  assign w_op_merged = (r_mask[OPW-1:0] & r_data[OPW-1:0]) | (~r_mask[OPW-1:0] & r_op_sr[OPOS]);
  assign w_ch_merged = (r_mask[CHW-1:0] & r_data[CHW-1:0]) | (~r_mask[CHW-1:0] & r_ch_sr[CPOS]);
  assign w_unused_bits = ^{r_data, r_mask};

  // Request handshake: a request is taken when wr_req=1, busy=0 and clk_en=1;
  // busy then stays high until the clk_en edge that commits the merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch   <= 3'd0;
      r_op   <= 2'd0;
      r_zero <= 1'b1;
      r_cidx <= 5'(OPOS);
      r_cch  <= 3'(CPOS);
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      r_ovr  <= 1'b0;
      r_isop <= 1'b0;
      r_tidx <= 5'd0;
      r_tch  <= 3'd0;
      r_data <= '0;
      r_mask <= '0;
    end else begin
      r_err <= 1'b0;
      if (clk_en) begin
        r_ch   <= w_ch_nxt;
        r_op   <= w_op_nxt;
        r_zero <= (w_ch_nxt == 3'd0) && (w_op_nxt == 2'd0);
        r_cidx <= (r_cidx == 5'(N - 1)) ? 5'd0 : r_cidx + 5'd1;
        r_cch  <= (r_cch == 3'(CH - 1)) ? 3'd0 : r_cch + 3'd1;
        if (w_op_hit || w_ch_hit) begin
          r_busy <= 1'b0;
        end
        if (wr_req) begin
          if (r_busy) begin
            r_ovr <= 1'b1;
          end else if (w_bad) begin
            r_err <= 1'b1;
          end else begin
            r_busy <= 1'b1;
            r_isop <= wr_isop;
            r_tidx <= w_tidx;
            r_tch  <= wr_ch;
            r_data <= wr_data;
            r_mask <= wr_mask;
          end
        end
      end
    end
  end

  // Element 0 is the presented word; the word leaving position 0 wraps to
  // the tail, and the commit-slot word is merged as it moves down one place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_op_sr[i] <= '0;
      for (int i = 0; i < CH; i++) r_ch_sr[i] <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < N; i++)
        r_op_sr[i] <= (((i + 1) % N == OPOS) && w_op_hit) ? w_op_merged : r_op_sr[(i + 1) % N];
      for (int i = 0; i < CH; i++)
        r_ch_sr[i] <= (((i + 1) % CH == CPOS) && w_ch_hit) ? w_ch_merged : r_ch_sr[(i + 1) % CH];
    end
  end

  assign busy    = r_busy;
  assign wr_err  = r_err;
  assign overrun = r_ovr;
  assign cur_ch  = r_ch;
  assign cur_op  = r_op;
  assign zero    = r_zero;
  assign op_q    = r_op_sr[0];
  assign ch_q    = r_ch_sr[0];

endmodule

// File: tb/tb_jt12_regseq.sv
// Bench for jt12_regseq: default instance plus a CH=3/OP=2/LAG=5 instance,
// checked every cycle against a slot-indexed reference model and a scoreboard.
module tb_jt12_regseq;

  typedef struct packed {
    logic        en, req, isop;
    logic [2:0]  ch;
    logic [1:0]  op;
    logic [43:0] data, mask;
  } in_t;

  typedef struct packed {
    logic        busy, err, ovr;
    logic [2:0]  ch;
    logic [1:0]  op;
    logic        zero;
    logic [43:0] opq;
    logic [30:0] chq;
  } obs_t;

  typedef struct {
    logic en;
    int   ch, op;
    logic zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  in0, in1;
  obs_t obs0, obs1;

  logic d0_busy, d0_err, d0_ovr, d0_zero, d1_busy, d1_err, d1_ovr, d1_zero;
  logic [2:0] d0_ch, d1_ch;
  logic [1:0] d0_op, d1_op;
  logic [43:0] d0_opq, d1_opq;
  logic [30:0] d0_chq, d1_chq;

  assign obs0 = {d0_busy, d0_err, d0_ovr, d0_ch, d0_op, d0_zero, d0_opq, d0_chq};
  assign obs1 = {d1_busy, d1_err, d1_ovr, d1_ch, d1_op, d1_zero, d1_opq, d1_chq};

  jt12_regseq u_dut0 (
    .clk(clk), .rst(rst), .clk_en(in0.en), .wr_req(in0.req), .wr_isop(in0.isop),
    .wr_ch(in0.ch), .wr_op(in0.op), .wr_data(in0.data), .wr_mask(in0.mask),
    .busy(d0_busy), .wr_err(d0_err), .overrun(d0_ovr), .cur_ch(d0_ch), .cur_op(d0_op),
    .zero(d0_zero), .op_q(d0_opq), .ch_q(d0_chq)
  );

  jt12_regseq #(.CH(3), .OP(2), .LAG(5)) u_dut1 (
    .clk(clk), .rst(rst), .clk_en(in1.en), .wr_req(in1.req), .wr_isop(in1.isop),
    .wr_ch(in1.ch), .wr_op(in1.op), .wr_data(in1.data), .wr_mask(in1.mask),
    .busy(d1_busy), .wr_err(d1_err), .overrun(d1_ovr), .cur_ch(d1_ch), .cur_op(d1_op),
    .zero(d1_zero), .op_q(d1_opq), .ch_q(d1_chq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state, one set per instance
  int          m_ch[2], m_op[2], m_tidx[2], m_tch[2], watch_idx[2];
  logic        m_zero[2], m_busy[2], m_err[2], m_ovr[2], m_isop[2];
  logic        watch[2], watch_isop[2];
  logic [43:0] m_data[2], m_mask[2];
  logic [43:0] ref_op[2][32];
  logic [30:0] ref_ch[2][8];
  logic [43:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int pch(int d);  return (d == 0) ? 6 : 3; endfunction
  function automatic int pop(int d);  return (d == 0) ? 4 : 2; endfunction
  function automatic int plag(int d); return (d == 0) ? 0 : 5; endfunction

  function automatic logic [43:0] mrg(logic [43:0] old, logic [43:0] dat, logic [43:0] msk);
    return (msk & dat) | (~msk & old);
  endfunction

  task automatic cmp(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %h, want %h", name, d, $time, act, exp);
    end
  endtask

  task automatic model_step(input int d, input in_t in);
    int  n, idx, cidx, tidx;
    logic ob;
    n    = pch(d) * pop(d);
    idx  = m_op[d] * pch(d) + m_ch[d];
    cidx = (idx + n - plag(d)) % n;
    ob   = m_busy[d];
    if (rst) begin
      m_ch[d] = 0; m_op[d] = 0; m_zero[d] = 1'b1;
      m_busy[d] = 1'b0; m_err[d] = 1'b0; m_ovr[d] = 1'b0; watch[d] = 1'b0;
      for (int i = 0; i < 32; i++) ref_op[d][i] = '0;
      for (int i = 0; i < 8; i++) ref_ch[d][i] = '0;
      exp_q.delete();
    end else if (in.en) begin
      if (ob && m_isop[d] && (m_tidx[d] == cidx)) begin
        ref_op[d][cidx] = mrg(ref_op[d][cidx], m_data[d], m_mask[d]);
        m_busy[d] = 1'b0; watch[d] = 1'b1; watch_isop[d] = 1'b1; watch_idx[d] = cidx;
      end else if (ob && !m_isop[d] && ((cidx % pch(d)) == m_tch[d])) begin
        ref_ch[d][m_tch[d]] = 31'(mrg({13'b0, ref_ch[d][m_tch[d]]}, m_data[d], m_mask[d]));
        m_busy[d] = 1'b0; watch[d] = 1'b1; watch_isop[d] = 1'b0; watch_idx[d] = m_tch[d];
      end
      m_err[d] = 1'b0;
      if (in.req) begin
        if (ob) m_ovr[d] = 1'b1;
        else if (int'(in.ch) >= pch(d) || (in.isop && int'(in.op) >= pop(d))) m_err[d] = 1'b1;
        else begin
          tidx = int'(in.op) * pch(d) + int'(in.ch);
          m_busy[d] = 1'b1; m_isop[d] = in.isop; m_tidx[d] = tidx; m_tch[d] = int'(in.ch);
          m_data[d] = in.data; m_mask[d] = in.mask;
          if (in.isop) exp_q.push_back(mrg(ref_op[d][tidx], in.data, in.mask));
          else exp_q.push_back({13'b0, 31'(mrg({13'b0, ref_ch[d][in.ch]}, in.data, in.mask))});
        end
      end
      m_ch[d]++;
      if (m_ch[d] == pch(d)) begin
        m_ch[d] = 0;
        m_op[d] = (m_op[d] + 1) % pop(d);
      end
      m_zero[d] = (m_ch[d] == 0) && (m_op[d] == 0);
    end else begin
      m_err[d] = 1'b0;
    end
  endtask

  task automatic check(input int d);
    obs_t o;
    int idx;
    logic [43:0] e;
    o   = (d == 0) ? obs0 : obs1;
    idx = m_op[d] * pch(d) + m_ch[d];
    cmp("slot", d, {o.ch, o.op, o.zero}, {3'(m_ch[d]), 2'(m_op[d]), m_zero[d]});
    cmp("flags", d, {o.busy, o.err, o.ovr}, {m_busy[d], m_err[d], m_ovr[d]});
    cmp("op_q", d, o.opq, ref_op[d][idx]);
    cmp("ch_q", d, o.chq, ref_ch[d][m_ch[d]]);
    if (watch[d] && ((watch_isop[d] && idx == watch_idx[d]) ||
                     (!watch_isop[d] && m_ch[d] == watch_idx[d]))) begin
      watch[d] = 1'b0;
      if (exp_q.size() == 0) cmp("sb_empty", d, 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        cmp("sb_word", d, watch_isop[d] ? o.opq : {13'b0, o.chq}, e);
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step(0, in0);
    model_step(1, in1);
    @(negedge clk);
    check(0);
    check(1);
  endtask

  task automatic drive_req(input int d, input logic isop, input logic [1:0] op,
                           input logic [2:0] ch, input logic [43:0] data, input logic [43:0] mask);
    if (d == 0) begin
      in0.req = 1'b1; in0.isop = isop; in0.op = op; in0.ch = ch; in0.data = data; in0.mask = mask;
    end else begin
      in1.req = 1'b1; in1.isop = isop; in1.op = op; in1.ch = ch; in1.data = data; in1.mask = mask;
    end
    tick();
    in0.req = 1'b0;
    in1.req = 1'b0;
  endtask

  task automatic wait_slot(input int d, input int op, input int ch);
    for (int i = 0; i < 64; i++) begin
      if (m_op[d] == op && m_ch[d] == ch) break;
      tick();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 120; i++) begin
      if (!m_busy[0] && !m_busy[1] && !watch[0] && !watch[1]) break;
      tick();
    end
    cmp("idle_bound", 0, {m_busy[0], m_busy[1], watch[0], watch[1]}, 64'd0);
  endtask

  vec_t tbl[28];

  initial begin
    int k, n_busy, n_err0, n_err1;
    logic pb;
    logic [4:0] prev_slot;
    logic [43:0] acc;

    k = 0;
    for (int i = 0; i < 28; i++) begin
      tbl[i].en   = (i < 24) ? 1'b1 : logic'(i % 2);
      tbl[i].ch   = k % 6;
      tbl[i].op   = (k / 6) % 4;
      tbl[i].zero = (k % 24) == 0;
      k += int'(tbl[i].en);
    end

    in0 = '0; in1 = '0;
    in0.en = 1'b1; in1.en = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // slot sweep after reset, then clk_en holds
    for (int i = 0; i < 28; i++) begin
      cmp("tbl_slot", 0, {d0_ch, d0_op, d0_zero}, {3'(tbl[i].ch), 2'(tbl[i].op), tbl[i].zero});
      cmp("tbl_op_q", 0, d0_opq, 64'd0);
      in0.en = tbl[i].en;
      tick();
    end
    in0.en = 1'b1;

    // operator write accepted while its own slot is visible
    wait_slot(0, 2, 3);
    drive_req(0, 1'b1, 2'd2, 3'd3, 44'h7F, 44'h7F);
    n_busy = int'(d0_busy);
    for (int i = 0; i < 29; i++) begin
      tick();
      n_busy += int'(d0_busy);
    end
    cmp("busy_cycles", 0, 64'(n_busy), 64'd24);
    wait_idle();
    wait_slot(0, 2, 3);
    cmp("op23", 0, d0_opq, 44'h7F);

    // channel writes: seed, then a 3-bit masked update
    drive_req(0, 1'b0, 2'd0, 3'd4, 44'h0_5555_5550, 44'hFFF_FFFF_FFFF);
    wait_idle();
    drive_req(0, 1'b0, 2'd3, 3'd4, 44'h5, 44'h7);
    wait_idle();
    for (int i = 0; i < 24; i++) begin
      if (m_ch[0] == 4) cmp("ch4_pass", 0, d0_chq, 31'h5555_5555);
      tick();
    end

    // out-of-range targets on both instances
    in0.req = 1'b1; in0.isop = 1'b0; in0.ch = 3'd6; in0.op = 2'd0; in0.data = 44'h3FF; in0.mask = '1;
    in1.req = 1'b1; in1.isop = 1'b1; in1.ch = 3'd0; in1.op = 2'd2; in1.data = 44'h3FF; in1.mask = '1;
    tick();
    in0.req = 1'b0; in1.req = 1'b0;
    n_err0 = int'(d0_err); n_err1 = int'(d1_err);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_err0 += int'(d0_err); n_err1 += int'(d1_err);
    end
    cmp("err_pulse", 0, 64'(n_err0), 64'd1);
    cmp("err_pulse", 1, 64'(n_err1), 64'd1);
    cmp("err_busy", 0, {d0_busy, d1_busy}, 64'd0);

    // second request while busy is lost and sets overrun
    drive_req(0, 1'b1, 2'd1, 3'd0, 44'hABC_DEF0_1234, 44'hFFF_FFFF_FFFF);
    drive_req(0, 1'b1, 2'd3, 3'd5, 44'h111, 44'hFFF);
    cmp("overrun", 0, d0_ovr, 64'd1);
    wait_idle();
    wait_slot(0, 1, 0);
    cmp("first_kept", 0, d0_opq, 44'hABC_DEF0_1234);
    wait_slot(0, 3, 5);
    cmp("second_lost", 0, d0_opq, 64'd0);

    // reset while a write is pending
    wait_slot(0, 0, 0);
    drive_req(0, 1'b1, 2'd0, 3'd0, 44'hFFFF, 44'hFFFF);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rst_busy", 0, {d0_busy, d0_ovr}, 64'd0);
    acc = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      acc |= d0_opq | {13'b0, d0_chq};
    end
    cmp("rst_clean", 0, acc, 64'd0);

    // wr_req held high: one request per busy-free cycle
    in0.req = 1'b1; in0.isop = 1'b0; in0.ch = 3'd1; in0.op = 2'd0; in0.data = 44'h3; in0.mask = 44'h3;
    for (int i = 0; i < 20; i++) tick();
    in0.req = 1'b0;
    cmp("held_ovr", 0, d0_ovr, 64'd1);
    wait_idle();

    // LAG=5 instance with clk_en toggling
    drive_req(1, 1'b1, 2'd1, 3'd2, 44'h1F, 44'h1F);
    pb = d1_busy;
    for (int i = 0; i < 40; i++) begin
      in1.en = logic'(i % 2);
      prev_slot = {d1_op, d1_ch};
      tick();
      if (pb && !d1_busy) begin
        cmp("lag_slot", 1, prev_slot, {2'd1, 3'd1});
        cmp("lag_vis", 1, {d1_op, d1_ch, d1_opq}, {2'd1, 3'd2, 44'h1F});
      end
      pb = d1_busy;
    end
    cmp("lag_done", 1, pb, 64'd0);
    in1.en = 1'b1;
    wait_idle();

    cmp("sb_drain", 0, 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
